alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter SEL_W, default 4, SHALL set the width of the Selection output (ALU input-2 mux select code).
REQ-002 Parameter CMD_W, default 3, SHALL set the width of CmdCode.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 CmdValid  input  1  SHALL indicate that a command is offered.
REQ-006 CmdCode  input  CMD_W  SHALL identify the command to sequence.
REQ-007 Stall  input  1  SHALL, when high, freeze the current step.
REQ-008 CmdReady  output  1  SHALL indicate that a command can be accepted.
REQ-009 Selection  output  SEL_W  SHALL drive the ALU input-2 mux select code.
REQ-010 StepValid  output  1  SHALL mark a cycle in which Selection belongs to an active step.
REQ-011 Last  output  1  SHALL mark the final step of the active command.
REQ-012 Done  output  1  SHALL pulse for one cycle when a command completes.
REQ-013 Error  output  1  SHALL pulse for one cycle when an illegal command is accepted.

Function
REQ-014 Select codes SHALL be: IN1=0, IN2=1, ONE=2, C96=3, C97=4, C144=5, ZERO=6.
REQ-015 Micro-sequences SHALL be: NOP(0)=ZERO; MOVE(1)=IN2; INC(2)=IN1,ONE; PUSH(3)=C96,ONE,IN2; POP(4)=C97,ONE,IN1; IOADDR(5)=C144,IN2.
REQ-016 Codes 6 and 7 SHALL be illegal.
REQ-017 The FSM SHALL have exactly two states: IDLE and RUN, plus a 2-bit step counter.
REQ-018 CmdReady SHALL be 1 in IDLE and 0 in RUN.
REQ-019 A command SHALL be accepted on a rising edge where CmdValid=1 and CmdReady=1; CmdCode is registered at acceptance.
REQ-020 A legal command SHALL move IDLE->RUN with step=0; the first step SHALL appear one cycle after acceptance.
REQ-021 In RUN, StepValid SHALL be 1, and Selection SHALL equal the table entry for (registered code, step).
REQ-022 In RUN with Stall=0, step SHALL increment each cycle; on Last with Stall=0 the FSM SHALL return to IDLE and Done SHALL pulse in the following cycle.
REQ-023 In RUN with Stall=1, step, Selection and Last SHALL hold.
REQ-024 Stall SHALL be ignored in IDLE.
REQ-025 An illegal command SHALL be consumed, SHALL remain in IDLE and SHALL pulse Error in the following cycle; no step is issued.
REQ-026 In IDLE, Selection SHALL be ZERO(6), StepValid=0 and Last=0.
REQ-027 Back-to-back commands SHALL be separated by at least one IDLE cycle; CmdValid during RUN SHALL be ignored.
REQ-028 Done and Error SHALL never assert in the same cycle.

Reset
REQ-029 Reset_n=0 SHALL immediately force: IDLE, step=0, CmdReady=1, Selection=6, StepValid=0, Last=0, Done=0, Error=0.
REQ-030 Reset asserted mid-command SHALL abort the command without asserting Done.

Configuration
REQ-031 With ALU_SEQ_PERF_EN defined, output CmdCount (16 bits) SHALL count completed legal commands, saturating at 0xFFFF, and reset to 0.
REQ-032 Without ALU_SEQ_PERF_EN, CmdCount and its counter SHALL be absent.

Structure
REQ-033 Select-code constants, command-code constants and CMD_W/SEL_W defaults SHALL reside in the shared package alu_seq_pkg.
REQ-034 The combinational micro-table SHALL be the sub-module alu_seq_rom: inputs (code, step); outputs (sel, last, illegal).

Verification
REQ-035 Reset, then MOVE (1) -> one cycle later Selection=1, StepValid=1, Last=1; the next cycle Done=1, CmdReady=1.
REQ-036 PUSH (3) with no stall -> Selection 3,2,1 on three consecutive cycles, with Last only on the third; Done follows.
REQ-037 POP (4) with Stall=1 for 2 cycles at step 1 -> Selection=2 held for 3 cycles, then 0; Done follows.
REQ-038 CmdCode=7 -> Error pulses 1 cycle, StepValid stays 0, and CmdReady stays 1.
REQ-039 INC (2), then Reset_n=0 during step 1 -> outputs reach reset values immediately; Done never asserts.
REQ-040 With ALU_SEQ_PERF_EN, 3 legal commands and 1 illegal command -> CmdCount=3.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operand sequencer: default widths, select codes,
// command codes and the FSM state type.
package alu_seq_pkg;

  localparam int SEL_W_DEF = 4;
  localparam int CMD_W_DEF = 3;

  localparam int SEL_IN1  = 0;
  localparam int SEL_IN2  = 1;
  localparam int SEL_ONE  = 2;
  localparam int SEL_C96  = 3;
  localparam int SEL_C97  = 4;
  localparam int SEL_C144 = 5;
  localparam int SEL_ZERO = 6;

  localparam int CMD_NOP    = 0;
  localparam int CMD_MOVE   = 1;
  localparam int CMD_INC    = 2;
  localparam int CMD_PUSH   = 3;
  localparam int CMD_POP    = 4;
  localparam int CMD_IOADDR = 5;

  typedef enum logic {ST_IDLE, ST_RUN} seq_state_t;

endpackage

// File: rtl/alu_seq_rom.sv
// Combinational micro-sequence table: maps (command, step) to an ALU input-2
// select code, flags the final step, and flags commands with no sequence.
module alu_seq_rom
  import alu_seq_pkg::*;
#(
  parameter int CMD_W = CMD_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [CMD_W-1:0] code,
  input  logic [1:0]       step,
  output logic [SEL_W-1:0] sel,
  output logic             last,
  output logic             illegal
);

  always_comb begin
    sel     = SEL_W'(SEL_ZERO);
    last    = 1'b1;
    illegal = 1'b0;
    case (code)
      CMD_W'(CMD_NOP):  sel = SEL_W'(SEL_ZERO);
      CMD_W'(CMD_MOVE): sel = SEL_W'(SEL_IN2);
      CMD_W'(CMD_INC): begin
        case (step)
          2'd0:    begin sel = SEL_W'(SEL_IN1); last = 1'b0; end
          default: sel = SEL_W'(SEL_ONE);
        endcase
      end
      CMD_W'(CMD_PUSH): begin
        case (step)
          2'd0:    begin sel = SEL_W'(SEL_C96); last = 1'b0; end
          2'd1:    begin sel = SEL_W'(SEL_ONE); last = 1'b0; end
          default: sel = SEL_W'(SEL_IN2);
        endcase
      end
      CMD_W'(CMD_POP): begin
        case (step)
          2'd0:    begin sel = SEL_W'(SEL_C97); last = 1'b0; end
          2'd1:    begin sel = SEL_W'(SEL_ONE); last = 1'b0; end
          default: sel = SEL_W'(SEL_IN1);
        endcase
      end
      CMD_W'(CMD_IOADDR): begin
        case (step)
          2'd0:    begin sel = SEL_W'(SEL_C144); last = 1'b0; end
          default: sel = SEL_W'(SEL_IN2);
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps the ALU input-2 mux through a per-command micro-sequence.
// Optional completed-command counter on CmdCount when ALU_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | ready for a command, Selection parked on ZERO
// RUN   | issuing steps of the registered command, one per unstalled cycle
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int CMD_W = CMD_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             CmdValid,
  input  logic [CMD_W-1:0] CmdCode,
  input  logic             Stall,
  output logic             CmdReady,
  output logic [SEL_W-1:0] Selection,
  output logic             StepValid,
  output logic             Last,
  output logic             Done,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]      CmdCount,
`endif
  output logic             Error
);

  seq_state_t       state;
  logic [CMD_W-1:0] code_q;
  logic [1:0]       step_q;
  logic [CMD_W-1:0] code_nx;
  logic [1:0]       step_nx;
  logic [SEL_W-1:0] rom_sel;
  logic             rom_last;
  logic             rom_illegal;

  // Look up the step about to be shown so Selection/Last can be registered.
  always_comb begin
    code_nx = code_q;
    step_nx = step_q + 2'd1;
    if (state == ST_IDLE) begin
      code_nx = CmdCode;
      step_nx = 2'd0;
    end
  end

  alu_seq_rom #(.CMD_W(CMD_W), .SEL_W(SEL_W)) u_rom (
    .code    (code_nx),
    .step    (step_nx),
    .sel     (rom_sel),
    .last    (rom_last),
    .illegal (rom_illegal)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      code_q    <= '0;
      step_q    <= 2'd0;
      CmdReady  <= 1'b1;
      Selection <= SEL_W'(SEL_ZERO);
      StepValid <= 1'b0;
      Last      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
`ifdef ALU_SEQ_PERF_EN
      CmdCount  <= 16'd0;
`endif
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CmdValid) begin
            if (rom_illegal) begin
              Error <= 1'b1;
            end else begin
              state     <= ST_RUN;
              code_q    <= CmdCode;
              step_q    <= 2'd0;
              CmdReady  <= 1'b0;
              Selection <= rom_sel;
              StepValid <= 1'b1;
              Last      <= rom_last;
            end
          end
        end
        ST_RUN: begin
          if (!Stall) begin
            if (Last) begin
              state     <= ST_IDLE;
              step_q    <= 2'd0;
              CmdReady  <= 1'b1;
              Selection <= SEL_W'(SEL_ZERO);
              StepValid <= 1'b0;
              Last      <= 1'b0;
              Done      <= 1'b1;
`ifdef ALU_SEQ_PERF_EN
              if (CmdCount != 16'hFFFF) CmdCount <= CmdCount + 16'd1;
`endif
            end else begin
              step_q    <= step_nx;
              Selection <= rom_sel;
              Last      <= rom_last;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: directed commands push their
// hand-computed step/Done/Error sequence; a negedge monitor pops and compares.
module tb_alu_operand_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       CmdValid;
  logic [2:0] CmdCode;
  logic       Stall;
  logic       CmdReady;
  logic [3:0] Selection;
  logic       StepValid;
  logic       Last;
  logic       Done;
  logic       Error;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] CmdCount;
`endif

  always #5 Clock = ~Clock;

  alu_operand_sequencer dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .CmdValid  (CmdValid),
    .CmdCode   (CmdCode),
    .Stall     (Stall),
    .CmdReady  (CmdReady),
    .Selection (Selection),
    .StepValid (StepValid),
    .Last      (Last),
    .Done      (Done),
`ifdef ALU_SEQ_PERF_EN
    .CmdCount  (CmdCount),
`endif
    .Error     (Error)
  );

  // kind is one-hot {Error, Done, StepValid}
  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] sel;
    logic       last;
    logic       ready;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void exp_step(input int sel, input bit last);
    q.push_back('{kind: 3'b001, sel: 4'(sel), last: last, ready: 1'b0});
  endfunction

  function automatic void exp_done();
    q.push_back('{kind: 3'b010, sel: 4'd6, last: 1'b0, ready: 1'b1});
  endfunction

  function automatic void exp_err();
    q.push_back('{kind: 3'b100, sel: 4'd6, last: 1'b0, ready: 1'b1});
  endfunction

  // Monitor: any cycle with StepValid/Done/Error consumes one expected entry.
  exp_t e;
  always @(negedge Clock) begin
    if (Reset_n && (StepValid || Done || Error)) begin
      if (q.size() == 0) begin
        check("unexpected_output", int'({Error, Done, StepValid}), 0);
      end else begin
        e = q.pop_front();
        check("kind", int'({Error, Done, StepValid}), int'(e.kind));
        check("selection", int'(Selection), int'(e.sel));
        check("last", int'(Last), int'(e.last));
        check("cmd_ready", int'(CmdReady), int'(e.ready));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(CmdReady), 1);
    check({tag, "_sel"}, int'(Selection), 6);
    check({tag, "_stepvalid"}, int'(StepValid), 0);
    check({tag, "_last"}, int'(Last), 0);
    check({tag, "_done"}, int'(Done), 0);
    check({tag, "_error"}, int'(Error), 0);
  endtask

  // Called and returns at a negedge. Runs nsteps+stall_n cycles after acceptance.
  task automatic issue(input int code, input int nsteps, input int stall_at,
                       input int stall_n, input bit stall_accept, input bit hold_valid);
    int t = 0;
    while (!CmdReady && t < 20) begin
      @(negedge Clock);
      t++;
    end
    if (!CmdReady) check("ready_timeout", 0, 1);
    CmdValid = 1'b1;
    CmdCode  = 3'(code);
    Stall    = stall_accept;
    @(posedge Clock);
    @(negedge Clock);
    CmdValid = hold_valid;
    CmdCode  = hold_valid ? 3'd1 : 3'(code);
    Stall    = 1'b0;
    for (int i = 0; i < nsteps + stall_n; i++) begin
      Stall = (i >= stall_at) && (i < stall_at + stall_n);
      @(posedge Clock);
      @(negedge Clock);
    end
    CmdValid = 1'b0;
    Stall    = 1'b0;
  endtask

  initial begin
    Reset_n  = 1'b0;
    CmdValid = 1'b0;
    CmdCode  = 3'd0;
    Stall    = 1'b0;
    #12;
    check_reset_outputs("reset");
`ifdef ALU_SEQ_PERF_EN
    check("count_reset", int'(CmdCount), 0);
`endif
    @(negedge Clock);
    Reset_n = 1'b1;

    // MOVE: IN2 with Last, then Done
    exp_step(1, 1); exp_done();
    issue(1, 1, -1, 0, 1'b0, 1'b0);
    // PUSH: C96, ONE, IN2; CmdValid held during RUN must be ignored
    exp_step(3, 0); exp_step(2, 0); exp_step(1, 1); exp_done();
    issue(3, 3, -1, 0, 1'b0, 1'b1);
    // POP stalled two cycles at step 1: ONE shown three times
    exp_step(4, 0); exp_step(2, 0); exp_step(2, 0); exp_step(2, 0); exp_step(0, 1); exp_done();
    issue(4, 3, 1, 2, 1'b0, 1'b0);
    // illegal 7: Error only, stays ready
    exp_err();
    issue(7, 0, -1, 0, 1'b0, 1'b0);
    @(negedge Clock);
    check("ready_after_illegal", int'(CmdReady), 1);
`ifdef ALU_SEQ_PERF_EN
    check("count_three", int'(CmdCount), 3);
`endif
    // illegal 6
    exp_err();
    issue(6, 0, -1, 0, 1'b0, 1'b0);
    // IOADDR with Stall high at acceptance (ignored in IDLE)
    exp_step(5, 0); exp_step(1, 1); exp_done();
    issue(5, 2, -1, 0, 1'b1, 1'b0);
    // NOP: single ZERO step
    exp_step(6, 1); exp_done();
    issue(0, 1, -1, 0, 1'b0, 1'b0);
    // INC full run with stall on the last step
    exp_step(0, 0); exp_step(2, 1); exp_step(2, 1); exp_done();
    issue(2, 2, 1, 1, 1'b0, 1'b0);
`ifdef ALU_SEQ_PERF_EN
    check("count_six", int'(CmdCount), 6);
`endif

    // INC aborted by reset during step 1: only step 0 is observed, no Done
    exp_step(0, 0);
    CmdValid = 1'b1;
    CmdCode  = 3'd2;
    @(posedge Clock);
    @(negedge Clock);
    CmdValid = 1'b0;
    @(posedge Clock);
    #2;
    check("step1_before_reset", int'(Selection), 2);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
`ifdef ALU_SEQ_PERF_EN
    check("count_after_reset", int'(CmdCount), 0);
`endif
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    check("no_done_after_abort", int'(Done), 0);

    repeat (2) @(negedge Clock);
    check("queue_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
